sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the free-running Sobel edge core. On a start command it resets the core and streams one IMG_WIDTH x IMG_HEIGHT greyscale frame from a synchronous-read pixel memory into the core, one pixel per cycle with no gaps. It captures exactly the valid edge results into a result memory, counts edge pixels, and reports done or error. It sits between the frame buffer / host control registers and the Sobel core.

Parameters:
IMG_WIDTH, 256, pixels per line; must match the core's IMG_WIDTH
IMG_HEIGHT, 256, lines per frame; must be >= 3
ADDR_W, 16, address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT
DRAIN_TIMEOUT, 1024, maximum DRAIN cycles before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle frame request; honoured in IDLE only
abort  in  1  cancel the current frame; any state
busy  out  1  high in CLR/FETCH/DRAIN
done  out  1  one-cycle pulse on successful frame completion
err  out  1  sticky drain-timeout flag; cleared by the next accepted start
mem_rd_en  out  1  pixel memory read strobe
mem_rd_addr  out  ADDR_W  pixel address, raster order
mem_rd_data  in  8  read data; valid exactly 1 cycle after mem_rd_en
core_rst  out  1  reset to the Sobel core, registered
core_pixel  out  8  pixel to the core; combinational copy of mem_rd_data
core_sobel  in  1  core edge bit
core_valid  in  1  core result-valid
res_wr_en  out  1  result memory write strobe
res_wr_addr  out  ADDR_W  result index 0..R-1
res_wr_data  out  1  edge bit
edge_count  out  ADDR_W  number of results == 1 in the last/current frame

Behaviour:
- Definitions: N = IMG_WIDTH*IMG_HEIGHT; R = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Reset values: state IDLE, core_rst=1, all other outputs 0, counters 0.
- IDLE:
  - core_rst=1.
  - start -> CLR: clears err, edge_count and result count.
  - start while busy is ignored.
- CLR:
  - One cycle, core_rst=1, then -> FETCH.
- FETCH:
  - Lasts exactly N cycles.
  - In cycle n (0..N-1): mem_rd_en=1, mem_rd_addr=n.
  - core_rst stays 1 in FETCH cycle 0 and is 0 from cycle 1 onward.
  - Pixel n therefore reaches core_pixel in cycle n+1, the core's first unreset sample, and the stream is gapless.
  - After cycle N-1 -> DRAIN.
- Result capture (FETCH and DRAIN):
  - Every cycle with core_valid=1 and result count < R, one cycle later: res_wr_en=1, res_wr_addr=result count, res_wr_data=core_sobel; then result count += 1 and edge_count += core_sobel.
  - core_valid after R results, or when not busy, is ignored. The core keeps sampling stale data after the frame ends.
- DRAIN:
  - mem_rd_en=0; core_pixel undefined.
  - Result count reaching R -> DONE.
  - DRAIN_TIMEOUT cycles without reaching R -> err=1 -> IDLE, with no done.
- DONE:
  - done=1 for one cycle, core_rst=1, -> IDLE.
  - edge_count holds until the next start.
- abort:
  - Any state -> IDLE next cycle.
  - core_rst=1; mem_rd_en, res_wr_en and busy drop next cycle.
  - No done; err unchanged.
  - abort and start in the same cycle: abort wins.
- Counter widths:
  - The pixel counter is ADDR_W wide and never wraps within a frame.
  - edge_count saturates at R.
- Simultaneous events: in the cycle the R-th write issues, the state goes to DONE. Any core_valid in that same cycle is ignored.

Optional Feature:
SOBEL_CTRL_PERF_EN
- Defined: adds output frame_cycles [31:0].
  - Cleared on start; increments every busy cycle; freezes on done, abort or err.
  - Saturates at all-ones; reset value 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
Run all scenarios with IMG_WIDTH=8, IMG_HEIGHT=6, so N=48 and R=24, using the real Sobel core plus behavioural 1-cycle memories.
1. Uniform frame (all 0x40) -> 24 writes at addresses 0..23, all res_wr_data=0, edge_count=0, one done pulse, err=0.
2. Vertical step (cols 0-3 = 0x00, cols 4-7 = 0xFF) -> write data matches a software Sobel model (threshold 100), edge_count equals the model's count, mem_rd_addr sequence 0..47 with no gaps.
3. start pulsed in FETCH cycle 10 -> ignored; done fires exactly once; address sequence unaffected.
4. abort in FETCH cycle 20 -> next cycle: busy=0, core_rst=1, mem_rd_en=0; no done. A following start completes a normal frame with 24 writes.
5. Core model with core_valid stuck 0 -> after DRAIN_TIMEOUT cycles: err=1, no done, state IDLE. The next start clears err.
6. Async rst asserted mid-DRAIN -> all outputs immediately at reset values and core_rst=1. With SOBEL_CTRL_PERF_EN defined, frame_cycles for a clean frame = 1+N+drain cycles, matching the bench count.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame sequencer feeding one image through the Sobel core
//
// Purpose: on start, hold the core in reset for one clear cycle, stream
// IMG_WIDTH*IMG_HEIGHT pixels gaplessly from a 1-cycle-latency pixel memory,
// capture the (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid core results into a result
// memory, count edge pixels and report done, or a sticky err on drain timeout.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      frame request (IDLE only) / cancel (any state, wins over start)
//   busy, done, err   status: CLR/FETCH/DRAIN, one-cycle completion pulse, sticky timeout
//   mem_rd_*          pixel memory read port (raster order)
//   core_*            Sobel core reset, pixel stream and result inputs
//   res_wr_*          result memory write port
//   edge_count        number of edge results in the last/current frame
//   frame_cycles      busy-cycle counter, present only with SOBEL_CTRL_PERF_EN
//
// Optional feature macro: SOBEL_CTRL_PERF_EN

module sobel_frame_ctrl #(
    parameter int IMG_WIDTH     = 256,
    parameter int IMG_HEIGHT    = 256,
    parameter int ADDR_W        = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              core_rst,
    output logic [7:0]        core_pixel,
    input  logic              core_sobel,
    input  logic              core_valid,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic              res_wr_data,
`ifdef SOBEL_CTRL_PERF_EN
    output logic [31:0]       frame_cycles,
`endif
    output logic [ADDR_W-1:0] edge_count
);

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] RES_NUM  = ADDR_W'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2));
    localparam int                DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]   res_cnt_q, res_cnt_d;
    logic [ADDR_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                err_q, err_d;
    logic                core_rst_q, core_rst_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_data_q, wr_data_d;
    logic                accept;
    logic                start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= '0;
            res_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            res_cnt_q   <= res_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        res_cnt_d   = res_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;

        start_ok = (state_q == S_IDLE) && start && !abort;

        // Results are counted when accepted, so the R-th write cycle already
        // sees res_cnt_q == R and any further core_valid is dropped.
        accept = core_valid && !abort && (res_cnt_q < RES_NUM) &&
                 ((state_q == S_FETCH) || (state_q == S_DRAIN));

        wr_en_d   = accept;
        wr_addr_d = res_cnt_q;
        wr_data_d = core_sobel;

        if (accept) begin
            res_cnt_d = res_cnt_q + 1'b1;
            if (core_sobel && (edge_cnt_q < RES_NUM)) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d     = S_CLR;
                    err_d       = 1'b0;
                    edge_cnt_d  = '0;
                    res_cnt_d   = '0;
                    pix_cnt_d   = '0;
                    drain_cnt_d = '0;
                end
            end
            S_CLR: state_d = S_FETCH;
            S_FETCH: begin
                if (pix_cnt_q == PIX_LAST) begin
                    pix_cnt_d = '0;
                    state_d   = S_DRAIN;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (res_cnt_q == RES_NUM) begin
                    state_d = S_DONE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            pix_cnt_d = '0;
        end

        // Core leaves reset one cycle into FETCH, so its first unreset sample
        // is pixel 0 arriving from the memory's read latency.
        core_rst_d = !((state_d == S_DRAIN) ||
                       ((state_d == S_FETCH) && (state_q == S_FETCH)));
    end

`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] frame_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cycles_q <= '0;
        end else if (start_ok) begin
            frame_cycles_q <= '0;
        end else if (busy && !abort && !(&frame_cycles_q)) begin
            frame_cycles_q <= frame_cycles_q + 32'd1;
        end
    end

    assign frame_cycles = frame_cycles_q;
`endif

    assign busy        = (state_q == S_CLR) || (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign mem_rd_en   = (state_q == S_FETCH);
    assign mem_rd_addr = pix_cnt_q;
    assign core_rst    = core_rst_q;
    assign core_pixel  = mem_rd_data;
    assign res_wr_en   = wr_en_q;
    assign res_wr_addr = wr_addr_q;
    assign res_wr_data = wr_data_q;
    assign edge_count  = edge_cnt_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - directed self-checking bench for sobel_frame_ctrl

module tb_sobel_frame_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int R  = (W - 2) * (H - 2);
    localparam int AW = 8;
    localparam int DT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, err;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          core_rst;
    logic [7:0]    core_pixel;
    logic          core_sobel = 1'b0;
    logic          core_valid = 1'b0;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic          res_wr_data;
    logic [AW-1:0] edge_count;
`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0]   frame_cycles;
`endif

    sobel_frame_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .core_rst(core_rst), .core_pixel(core_pixel),
        .core_sobel(core_sobel), .core_valid(core_valid),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
`ifdef SOBEL_CTRL_PERF_EN
        .frame_cycles(frame_cycles),
`endif
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] img  [N];
    logic [7:0] cbuf [N];
    int         cpos = 0;
    bit         stuck = 1'b0;

    // Reference Sobel on a 3x3 window, threshold |gx|+|gy| > 100.
    function automatic bit sobel3(input int p [9]);
        int gx, gy;
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) > 100;
    endfunction

    function automatic bit ref_edge(input int r, input int c);
        int p [9];
        for (int i = 0; i < 9; i++) p[i] = int'(img[(r - 1 + i / 3) * W + (c - 1 + i % 3)]);
        return sobel3(p);
    endfunction

    function automatic int cpix(input int idx);
        return (idx == cpos) ? int'(core_pixel) : int'(cbuf[idx]);
    endfunction

    function automatic bit core_edge(input int r, input int c);
        int p [9];
        if (r < 1 || c < 1) return 1'b0;
        for (int i = 0; i < 9; i++) p[i] = cpix((r - 1 + i / 3) * W + (c - 1 + i % 3));
        return sobel3(p);
    endfunction

    // Pixel memory with one-cycle read latency.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= img[mem_rd_addr];

    // Free-running core model: result for centre (r-1,c-1) one cycle after pixel (r,c).
    always @(posedge clk) begin
        if (core_rst) begin
            cpos       <= 0;
            core_valid <= 1'b0;
            core_sobel <= 1'b0;
        end else begin
            cbuf[cpos] <= core_pixel;
            core_valid <= !stuck && (cpos / W >= 2) && (cpos % W >= 2);
            core_sobel <= core_edge(cpos / W - 1, cpos % W - 1);
            cpos       <= (cpos == N - 1) ? 0 : cpos + 1;
        end
    end

    int rd_n, rd_bad, wr_n, done_n, busy_n;
    logic [AW-1:0] wr_addr_log [64];
    logic          wr_data_log [64];

    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (int'(mem_rd_addr) != rd_n) rd_bad++;
            rd_n++;
        end
        if (res_wr_en && wr_n < 64) begin
            wr_addr_log[wr_n] = res_wr_addr;
            wr_data_log[wr_n] = res_wr_data;
            wr_n++;
        end
        if (done) done_n++;
        if (busy) busy_n++;
    end

    task automatic clr_mon();
        rd_n = 0; rd_bad = 0; wr_n = 0; done_n = 0; busy_n = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input string name);
        bit ok;
        clr_mon();
        pulse_start();
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL %s_timeout: busy never dropped", name); end
    endtask

    task automatic check_results(input string name, input int exp_edges);
        int k = 0;
        tests++;
        if (wr_n !== R) begin fails++; $display("FAIL %s_wr_count: got %0d want %0d", name, wr_n, R); end
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                tests++;
                if (wr_addr_log[k] !== AW'(k) || wr_data_log[k] !== ref_edge(r, c)) begin
                    fails++;
                    $display("FAIL %s_wr[%0d]: got addr %0d data %0b want addr %0d data %0b",
                             name, k, wr_addr_log[k], wr_data_log[k], k, ref_edge(r, c));
                end
                k++;
            end
        end
        tests++;
        if (edge_count !== AW'(exp_edges)) begin
            fails++; $display("FAIL %s_edge_count: got %0d want %0d", name, edge_count, exp_edges);
        end
        tests++;
        if (done_n !== 1 || err !== 1'b0) begin
            fails++; $display("FAIL %s_done_err: got done %0d err %0b want 1 0", name, done_n, err);
        end
        tests++;
        if (rd_n !== N || rd_bad !== 0) begin
            fails++; $display("FAIL %s_rd_seq: got %0d reads %0d gaps want %0d 0", name, rd_n, rd_bad, N);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || core_rst !== 1'b1 ||
            mem_rd_en !== 1'b0 || res_wr_en !== 1'b0 || edge_count !== '0 || mem_rd_addr !== '0) begin
            fails++;
            $display("FAIL reset_state: busy %0b done %0b err %0b core_rst %0b rd_en %0b wr_en %0b edges %0d",
                     busy, done, err, core_rst, mem_rd_en, res_wr_en, edge_count);
        end
    endtask

    task automatic test_uniform();
        for (int i = 0; i < N; i++) img[i] = 8'h40;
        run_frame("uniform");
        check_results("uniform", 0);
`ifdef SOBEL_CTRL_PERF_EN
        tests++;
        if (frame_cycles !== 32'(busy_n)) begin
            fails++; $display("FAIL perf_cycles: got %0d want %0d", frame_cycles, busy_n);
        end
`endif
    endtask

    task automatic test_vertical_step();
        for (int i = 0; i < N; i++) img[i] = (i % W >= 4) ? 8'hFF : 8'h00;
        run_frame("vstep");
        // Centres in columns 3 and 4 straddle the step: 2 per row, 4 rows.
        check_results("vstep", 8);
    endtask

    task automatic test_start_in_fetch();
        bit ok, seen;
        for (int i = 0; i < N; i++) img[i] = 8'(i * 5);
        clr_mon();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (mem_rd_en && mem_rd_addr == AW'(10)) seen = 1'b1;
            else @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle(ok);
        tests++;
        if (!seen || !ok) begin fails++; $display("FAIL start_fetch_timeout: seen %0b idle %0b", seen, ok); end
        check_results("start_fetch", edge_count);
        repeat (5) @(negedge clk);
        tests++;
        if (done_n !== 1 || busy !== 1'b0) begin
            fails++; $display("FAIL start_fetch_retrigger: got done %0d busy %0b want 1 0", done_n, busy);
        end
    endtask

    task automatic test_abort();
        bit seen;
        for (int i = 0; i < N; i++) img[i] = (i / W >= 3) ? 8'hC0 : 8'h10;
        clr_mon();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (mem_rd_en && mem_rd_addr == AW'(20)) seen = 1'b1;
            else @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        tests++;
        if (!seen || busy !== 1'b0 || core_rst !== 1'b1 || mem_rd_en !== 1'b0 || res_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_next: seen %0b busy %0b core_rst %0b rd_en %0b wr_en %0b want 1 0 1 0 0",
                     seen, busy, core_rst, mem_rd_en, res_wr_en);
        end
        repeat (DT + 10) @(negedge clk);
        tests++;
        if (done_n !== 0 || err !== 1'b0) begin
            fails++; $display("FAIL abort_no_done: got done %0d err %0b want 0 0", done_n, err);
        end
        run_frame("after_abort");
        check_results("after_abort", edge_count);
    endtask

    task automatic test_timeout();
        bit ok;
        stuck = 1'b1;
        run_frame("timeout");
        tests++;
        if (err !== 1'b1 || done_n !== 0 || busy !== 1'b0 || wr_n !== 0) begin
            fails++; $display("FAIL timeout_err: got err %0b done %0d busy %0b writes %0d want 1 0 0 0",
                              err, done_n, busy, wr_n);
        end
        tests++;
        if (busy_n !== 1 + N + DT) begin
            fails++; $display("FAIL timeout_len: got %0d busy cycles want %0d", busy_n, 1 + N + DT);
        end
        stuck = 1'b0;
        clr_mon();
        pulse_start();
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL err_clear: got err %0b busy %0b want 0 1", err, busy);
        end
        wait_idle(ok);
        tests++;
        if (!ok || done_n !== 1 || err !== 1'b0) begin
            fails++; $display("FAIL after_timeout: idle %0b done %0d err %0b want 1 1 0", ok, done_n, err);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N; i++) img[i] = (i % W >= 4) ? 8'hFF : 8'h00;
        clr_mon();
        pulse_start();
        for (int i = 0; i < 200 && rd_n < N; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || core_rst !== 1'b1 || mem_rd_en !== 1'b0 ||
            res_wr_en !== 1'b0 || edge_count !== '0 || res_wr_addr !== '0 || mem_rd_addr !== '0 || rd_n !== N) begin
            fails++;
            $display("FAIL async_reset: busy %0b done %0b err %0b core_rst %0b rd_en %0b wr_en %0b edges %0d reads %0d",
                     busy, done, err, core_rst, mem_rd_en, res_wr_en, edge_count, rd_n);
        end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_uniform();
        test_vertical_step();
        test_start_in_fetch();
        test_abort();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
